resonator_dds_mul_pipe: RTL and testbench

Parametrised signed pipelined multiplier for the resonator DDS datapath: the next generation of the fixed 17x16 DSP48 multiplier. It adds configurable operand/result widths, configurable pipeline depth and a fixed-point output shift. A valid flag travels alongside the data. Reset is functional and clears the pipeline. It sits between the phase-to-amplitude lookup and the per-channel mixer/accumulator stages and maps onto DSP48 slices.

---
 rtl/resonator_dds_mul_pipe.sv | 106 ++++++++++
 tb/tb_resonator_dds_mul_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resonator_dds_mul_pipe.sv
// Signed pipelined multiplier with scaled, width-reduced output and a valid pipe that runs alongside.
// RESONATOR_DDS_MUL_ROUND_EN selects round-half-up with saturation instead of floor with wrap.
module resonator_dds_mul_pipe #(
  parameter int unsigned DIN0_WIDTH = 17,
  parameter int unsigned DIN1_WIDTH = 16,
  parameter int unsigned DOUT_WIDTH = 33,
  parameter int unsigned NUM_STAGE  = 2,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int unsigned PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned WW  = SW + DOUT_WIDTH;
  localparam int unsigned MID = NUM_STAGE - 2;

  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic        [NUM_STAGE-1:0]  vld_q;
  logic signed [PW-1:0]         prod_c;
  logic signed [PW-1:0]         p_last;

  assign prod_c = PW'(a_q) * PW'(b_q);

  generate
    if (MID == 0) begin : g_nomid
      assign p_last = prod_c;
    end else begin : g_mid
      logic signed [PW-1:0] p_q [MID];
      always_ff @(posedge clk) begin
        if (reset) begin
          p_q <= '{default: '0};
        end else if (ce) begin
          p_q[0] <= prod_c;
          for (int i = 1; i < MID; i++) begin
            p_q[i] <= p_q[i-1];
          end
        end
      end
      assign p_last = p_q[MID-1];
    end
  endgenerate

`ifdef RESONATOR_DDS_MUL_ROUND_EN
  localparam logic signed [SW-1:0] BIAS =
      (SHIFT == 0) ? '0 : (SW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [DOUT_WIDTH-1:0] DMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] DMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
`endif

  logic signed [SW-1:0]         s_full;
  logic signed [WW-1:0]         s_ext;
  logic signed [WW-1:0]         s_back;
  logic signed [DOUT_WIDTH-1:0] s_trunc;
  logic signed [DOUT_WIDTH-1:0] dout_d;
  logic                         fits;
  logic                         ovf_d;

  // One extra bit of headroom keeps the rounding bias from overflowing the product.
  always_comb begin
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    s_full = (SW'(p_last) + BIAS) >>> SHIFT;
`else
    s_full = SW'(p_last) >>> SHIFT;
`endif
    s_ext   = WW'(s_full);
    s_trunc = s_ext[DOUT_WIDTH-1:0];
    s_back  = WW'(s_trunc);
    fits    = (s_back == s_ext);
    ovf_d   = ~fits;
    dout_d  = s_trunc;
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    if (!fits) begin
      dout_d = s_ext[WW-1] ? DMIN : DMAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
    end else if (ce) begin
      a_q   <= din0;
      b_q   <= din1;
      vld_q <= {vld_q[NUM_STAGE-2:0], in_valid};
      dout  <= dout_d;
      ovf   <= ovf_d;
    end
  end

  assign out_valid = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_resonator_dds_mul_pipe.sv
// Directed checks of resonator_dds_mul_pipe across four parameterisations sharing one clock/reset.
module tb_resonator_dds_mul_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Default config
  logic d0_ce, d0_iv, d0_ov, d0_ovf;
  logic signed [16:0] d0_a;
  logic signed [15:0] d0_b;
  logic signed [32:0] d0_dout;
  // SHIFT=1
  logic s1_ce, s1_iv, s1_ov, s1_ovf;
  logic signed [16:0] s1_a;
  logic signed [15:0] s1_b;
  logic signed [32:0] s1_dout;
  // DOUT_WIDTH=16, SHIFT=15
  logic ov_ce, ov_iv, ov_ov, ov_ovf;
  logic signed [16:0] ov_a;
  logic signed [15:0] ov_b;
  logic signed [15:0] ov_dout;
  // NUM_STAGE=4
  logic n4_ce, n4_iv, n4_ov, n4_ovf;
  logic signed [16:0] n4_a;
  logic signed [15:0] n4_b;
  logic signed [32:0] n4_dout;

  resonator_dds_mul_pipe u_d0 (
    .clk(clk), .reset(reset), .ce(d0_ce), .in_valid(d0_iv), .din0(d0_a), .din1(d0_b),
    .out_valid(d0_ov), .dout(d0_dout), .ovf(d0_ovf)
  );
  resonator_dds_mul_pipe #(.SHIFT(1)) u_s1 (
    .clk(clk), .reset(reset), .ce(s1_ce), .in_valid(s1_iv), .din0(s1_a), .din1(s1_b),
    .out_valid(s1_ov), .dout(s1_dout), .ovf(s1_ovf)
  );
  resonator_dds_mul_pipe #(.DOUT_WIDTH(16), .SHIFT(15)) u_ov (
    .clk(clk), .reset(reset), .ce(ov_ce), .in_valid(ov_iv), .din0(ov_a), .din1(ov_b),
    .out_valid(ov_ov), .dout(ov_dout), .ovf(ov_ovf)
  );
  resonator_dds_mul_pipe #(.NUM_STAGE(4)) u_n4 (
    .clk(clk), .reset(reset), .ce(n4_ce), .in_valid(n4_iv), .din0(n4_a), .din1(n4_b),
    .out_valid(n4_ov), .dout(n4_dout), .ovf(n4_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent model of the 16-bit, shift-15 build: returns {ovf, dout}.
  function automatic logic [16:0] ref16(input longint p);
    longint s;
    logic [15:0] d;
    logic o;
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    s = (p + 64'sd16384) >>> 15;
`else
    s = p >>> 15;
`endif
    o = (s > 64'sd32767) || (s < -64'sd32768);
    d = s[15:0];
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    if (s > 64'sd32767) d = 16'h7fff;
    if (s < -64'sd32768) d = 16'h8000;
`endif
    return {o, d};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if ({d0_ov, d0_dout, d0_ovf} !== 35'd0) begin
      err_cnt++;
      $display("FAIL reset_d0: got v=%b d=%0d o=%b want 0/0/0", d0_ov, d0_dout, d0_ovf);
    end
    vec_cnt++;
    if ({ov_ov, ov_dout, ov_ovf} !== 18'd0) begin
      err_cnt++;
      $display("FAIL reset_ov: got v=%b d=%0d o=%b want 0/0/0", ov_ov, ov_dout, ov_ovf);
    end
    vec_cnt++;
    if ({n4_ov, n4_dout, n4_ovf} !== 35'd0) begin
      err_cnt++;
      $display("FAIL reset_n4: got v=%b d=%0d o=%b want 0/0/0", n4_ov, n4_dout, n4_ovf);
    end
    reset = 1'b0;
  endtask

  task automatic test_default_product();
    d0_a = -17'sd65536; d0_b = -16'sd32768; d0_iv = 1'b1;
    tick();
    d0_iv = 1'b0;
    vec_cnt++;
    if (d0_ov !== 1'b0) begin
      err_cnt++;
      $display("FAIL dflt_early_valid: got %b want 0", d0_ov);
    end
    tick();
    vec_cnt++;
    if (d0_ov !== 1'b1 || d0_dout !== 33'sd2147483648 || d0_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL dflt_product: got v=%b d=%0d o=%b want 1/2147483648/0",
               d0_ov, d0_dout, d0_ovf);
    end
    tick();
    vec_cnt++;
    if (d0_ov !== 1'b0) begin
      err_cnt++;
      $display("FAIL dflt_valid_drop: got %b want 0", d0_ov);
    end
  endtask

  task automatic test_shift1();
    logic signed [32:0] e0, e1;
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    e0 = 33'sd2; e1 = -33'sd1;
`else
    e0 = 33'sd1; e1 = -33'sd2;
`endif
    s1_a = 17'sd3; s1_b = 16'sd1; s1_iv = 1'b1;
    tick();
    s1_a = -17'sd3;
    tick();
    s1_iv = 1'b0;
    vec_cnt++;
    if (s1_ov !== 1'b1 || s1_dout !== e0) begin
      err_cnt++;
      $display("FAIL shift1_pos: got v=%b d=%0d want 1/%0d", s1_ov, s1_dout, e0);
    end
    tick();
    vec_cnt++;
    if (s1_ov !== 1'b1 || s1_dout !== e1) begin
      err_cnt++;
      $display("FAIL shift1_neg: got v=%b d=%0d want 1/%0d", s1_ov, s1_dout, e1);
    end
  endtask

  task automatic test_ovf();
    logic signed [16:0] ta [3] = '{17'sd65535, -17'sd65536, -17'sd65536};
    logic signed [15:0] tb [3] = '{16'sd32767, 16'sd1, 16'sd32767};
    logic signed [15:0] ed [3];
    logic eo [3] = '{1'b1, 1'b0, 1'b1};
`ifdef RESONATOR_DDS_MUL_ROUND_EN
    ed = '{16'sd32767, -16'sd2, -16'sd32768};
`else
    ed = '{-16'sd3, -16'sd2, 16'sd2};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        ov_a = ta[i]; ov_b = tb[i]; ov_iv = 1'b1;
      end else begin
        ov_iv = 1'b0;
      end
      tick();
      if (i >= 1) begin
        vec_cnt++;
        if (ov_ov !== 1'b1 || ov_dout !== ed[i-1] || ov_ovf !== eo[i-1]) begin
          err_cnt++;
          $display("FAIL ovf_vec%0d: got v=%b d=%0d o=%b want 1/%0d/%b",
                   i - 1, ov_ov, ov_dout, ov_ovf, ed[i-1], eo[i-1]);
        end
      end
    end
  endtask

  task automatic test_ce_toggle();
    logic signed [16:0] ta [8] = '{17'sd3, -17'sd7, 17'sd65535, -17'sd65536,
                                   17'sd12345, -17'sd1, 17'sd0, 17'sd40000};
    logic signed [15:0] tb [8] = '{16'sd5, 16'sd9, 16'sd32767, 16'sd32767,
                                   -16'sd321, -16'sd1, 16'sd777, -16'sd20000};
    logic signed [32:0] tp [8] = '{33'sd15, -33'sd63, 33'sd2147385345, -33'sd2147418112,
                                   -33'sd3962745, 33'sd1, 33'sd0, -33'sd800000000};
    int e = 0;
    logic exp_v = 1'b0;
    logic signed [32:0] exp_d = '0;
    for (int c = 0; c < 24; c++) begin
      n4_ce = (c % 2 == 0);
      if (n4_ce) begin
        if (e < 8) begin
          n4_a = ta[e]; n4_b = tb[e]; n4_iv = 1'b1;
        end else begin
          n4_iv = 1'b0;
        end
      end
      tick();
      if (n4_ce) begin
        exp_v = (e >= 3) && (e - 3 < 8);
        if (exp_v) exp_d = tp[e-3];
        e++;
      end
      vec_cnt++;
      if (n4_ov !== exp_v || (exp_v && (n4_dout !== exp_d || n4_ovf !== 1'b0))) begin
        err_cnt++;
        $display("FAIL ce_toggle_c%0d: got v=%b d=%0d o=%b want %b/%0d/0",
                 c, n4_ov, n4_dout, n4_ovf, exp_v, exp_d);
      end
    end
    n4_ce = 1'b1;
    n4_iv = 1'b0;
  endtask

  task automatic test_reset_inflight();
    n4_ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n4_a = 17'sd100 + 17'(i); n4_b = 16'sd7; n4_iv = 1'b1;
      tick();
    end
    n4_iv = 1'b0;
    n4_ce = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (n4_ov !== 1'b0 || n4_dout !== 33'sd0 || n4_ovf !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_inflight: got v=%b d=%0d o=%b want 0/0/0", n4_ov, n4_dout, n4_ovf);
    end
    n4_ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec_cnt++;
      if (n4_ov !== 1'b0) begin
        err_cnt++;
        $display("FAIL reset_flush_c%0d: got valid %b want 0", i, n4_ov);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    logic signed [32:0] e_d0 [N];
    logic [16:0] e_ov [N];
    logic [31:0] r;
    longint p;
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        r = $urandom(); d0_a = r[16:0];
        r = $urandom(); d0_b = r[15:0];
        r = $urandom(); ov_a = r[16:0];
        r = $urandom(); ov_b = r[15:0];
        d0_iv = 1'b1; ov_iv = 1'b1;
        p = longint'(d0_a) * longint'(d0_b);
        e_d0[i] = p[32:0];
        e_ov[i] = ref16(longint'(ov_a) * longint'(ov_b));
      end else begin
        d0_iv = 1'b0; ov_iv = 1'b0;
      end
      tick();
      if (i >= 1) begin
        vec_cnt++;
        if (d0_ov !== 1'b1 || d0_dout !== e_d0[i-1] || d0_ovf !== 1'b0) begin
          err_cnt++;
          $display("FAIL rand_d0_%0d: got v=%b d=%0d o=%b want 1/%0d/0",
                   i - 1, d0_ov, d0_dout, d0_ovf, e_d0[i-1]);
        end
        vec_cnt++;
        if (ov_ov !== 1'b1 || {ov_ovf, ov_dout} !== e_ov[i-1]) begin
          err_cnt++;
          $display("FAIL rand_ov_%0d: got v=%b o=%b d=%h want 1/%b/%h",
                   i - 1, ov_ov, ov_ovf, ov_dout, e_ov[i-1][16], e_ov[i-1][15:0]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    d0_ce = 1'b1; d0_iv = 1'b0; d0_a = '0; d0_b = '0;
    s1_ce = 1'b1; s1_iv = 1'b0; s1_a = '0; s1_b = '0;
    ov_ce = 1'b1; ov_iv = 1'b0; ov_a = '0; ov_b = '0;
    n4_ce = 1'b1; n4_iv = 1'b0; n4_a = '0; n4_b = '0;
    test_reset();
    test_default_product();
    test_shift1();
    test_ovf();
    test_ce_toggle();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
